inst_fetch: RTL

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 120 ++++++++++++
 1 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch: registered instmem address, one-cycle read latency, 2-entry prefetch FIFO.
// Define FETCH_HALT_EN to stop fetching after an all-ones instruction word returns.
`ifndef INSTMEM_ADDR_WIDTH
`define INSTMEM_ADDR_WIDTH 8
`endif
`ifndef INSTMEM_WORDSIZE
`define INSTMEM_WORDSIZE 16
`endif

module inst_fetch (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    output logic [`INSTMEM_ADDR_WIDTH-1:0] AR,
    input  logic [`INSTMEM_WORDSIZE-1:0]   Q,
    input  logic                           branch_valid,
    input  logic [`INSTMEM_ADDR_WIDTH-1:0] branch_target,
    output logic                           inst_valid,
    input  logic                           inst_ready,
    output logic [`INSTMEM_WORDSIZE-1:0]   inst_out,
    output logic [`INSTMEM_ADDR_WIDTH-1:0] pc_out,
    output logic                           halted
);

    localparam int AW = `INSTMEM_ADDR_WIDTH;
    localparam int DW = `INSTMEM_WORDSIZE;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HALT = 2'd2;

    logic [1:0]    state;
    logic          inflight;
    logic [AW-1:0] inflight_addr;
    logic [DW-1:0] fifo_word [2];
    logic [AW-1:0] fifo_pc   [2];
    logic          rd_ptr;
    logic [1:0]    count;

    logic          pop;
    logic          flush;
    logic          halt_hit;
    logic [2:0]    occ;
    logic          issue;
    logic          wr;
    logic          pop_eff;
    logic          wr_ptr;

    assign pop   = inst_valid && inst_ready;
    assign flush = branch_valid && (state != IDLE);

`ifdef FETCH_HALT_EN
    assign halt_hit = inflight && (Q == {DW{1'b1}});
    assign halted   = (state == HALT);
`else
    assign halt_hit = 1'b0;
    assign halted   = 1'b0;
`endif

    // Occupancy the FIFO will have once this cycle's return and pop settle
    assign occ = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign issue   = (state == RUN) && !flush && !halt_hit && (occ < 3'd2);
    assign wr      = inflight && !flush;
    assign pop_eff = pop && !flush;
    assign wr_ptr  = rd_ptr ^ count[0];

    assign inst_valid = (count != 2'd0);
    assign inst_out   = fifo_word[rd_ptr];
    assign pc_out     = fifo_pc[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            AR            <= '0;
            inflight      <= 1'b0;
            inflight_addr <= '0;
        end else begin
            if (flush) begin
                state <= RUN;
            end else if ((state == IDLE) && start) begin
                state <= RUN;
            end else if (halt_hit) begin
                state <= HALT;
            end

            if (flush) begin
                AR <= branch_target;
            end else if (issue) begin
                AR <= AR + 1'b1;
            end

            inflight      <= issue;
            inflight_addr <= AR;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr       <= 1'b0;
            count        <= 2'd0;
            fifo_word[0] <= '0;
            fifo_word[1] <= '0;
            fifo_pc[0]   <= '0;
            fifo_pc[1]   <= '0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (wr) begin
                fifo_word[wr_ptr] <= Q;
                fifo_pc[wr_ptr]   <= inflight_addr;
            end
            if (pop_eff) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, wr} - {1'b0, pop_eff};
        end
    end

endmodule
